// File: rtl/uart_rx_drain.sv
// uart_rx_drain: drains received bytes from the UART core into a small
// show-ahead FIFO and presents them on a valid/ready stream.
//
// Ports:
//   CLK, RESET       clock, asynchronous active-high reset
//   RXRDY            UART byte-ready
//   DATA_OUT         UART receive byte, valid while RXRDY=1
//   PARITY_ERR       UART parity error for the byte on DATA_OUT
//   FRAMING_ERR      UART framing error for the byte on DATA_OUT
//   OVERFLOW         UART overflow indication
//   CSN, OEN         active-low UART select / read strobe (registered)
//   m_valid          stream head valid
//   m_ready          consumer accepts the head
//   m_data           head byte
//   m_perr, m_ferr   head byte error flags
//   clr_stat         clears drop_cnt and ovf_seen
//   drop_cnt         saturating count of discarded bytes
//   ovf_seen         sticky overflow flag
//
// Parameters:
//   DEPTH            FIFO entries, power of two 2..16
//   DROP_ERR         1 = discard bytes with parity/framing error

module uart_rx_drain #(
    parameter int DEPTH    = 4,
    parameter bit DROP_ERR = 1'b0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RXRDY,
    input  logic [7:0] DATA_OUT,
    input  logic       PARITY_ERR,
    input  logic       FRAMING_ERR,
    input  logic       OVERFLOW,
    output logic       CSN,
    output logic       OEN,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       m_perr,
    output logic       m_ferr,
    input  logic       clr_stat,
    output logic [7:0] drop_cnt,
    output logic       ovf_seen
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        GUARD
    } state_t;

    state_t      state;
    logic [1:0]  gcnt;

    logic [AW:0]   count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_nxt;
    logic [9:0]    mem [DEPTH];
    logic [9:0]    head;
    logic [9:0]    wdata;

    logic cap;
    logic err;
    logic drop;
    logic push;
    logic pop;

    // The byte is taken at the edge that ends READ; DATA_OUT and the error
    // flags are still driven by the UART at that edge.
    always_comb begin
        cap    = (state == READ);
        err    = PARITY_ERR | FRAMING_ERR;
        drop   = cap & DROP_ERR & err;
        push   = cap & ~drop;
        m_valid = (count != '0);
        pop    = m_valid & m_ready;
        wdata  = {FRAMING_ERR, PARITY_ERR, DATA_OUT};
        rd_nxt = rd_ptr + PTR_ONE;
    end

    // Read sequencer. GUARD spans the UART's RXRDY clear latency so the
    // stale RXRDY after a read never starts a second read of the same byte.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            gcnt  <= 2'd0;
            CSN   <= 1'b1;
            OEN   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (RXRDY && (count < FULL)) begin
                        state <= READ;
                        CSN   <= 1'b0;
                        OEN   <= 1'b0;
                    end
                end
                READ: begin
                    state <= GUARD;
                    gcnt  <= 2'd0;
                    CSN   <= 1'b1;
                    OEN   <= 1'b1;
                end
                GUARD: begin
                    if (gcnt == 2'd2) begin
                        state <= IDLE;
                        gcnt  <= 2'd0;
                    end else begin
                        gcnt <= gcnt + 2'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gcnt  <= 2'd0;
                    CSN   <= 1'b1;
                    OEN   <= 1'b1;
                end
            endcase
        end
    end

    // Storage needs no reset: only slots between rd_ptr and wr_ptr are read.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers, count and a registered copy of the head entry. The head
    // register keeps the last head while empty instead of exposing an
    // unrelated storage slot.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_nxt;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (push && ((count == '0) || (pop && (count == CNT_ONE)))) begin
                head <= wdata;
            end else if (pop && (count > CNT_ONE)) begin
                head <= mem[rd_nxt];
            end
        end
    end

    assign m_data = head[7:0];
    assign m_perr = head[8];
    assign m_ferr = head[9];

    // Status: overflow set beats clear; counter clear beats increment.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ovf_seen <= 1'b0;
            drop_cnt <= 8'h00;
        end else begin
            if (OVERFLOW) begin
                ovf_seen <= 1'b1;
            end else if (clr_stat) begin
                ovf_seen <= 1'b0;
            end
            if (clr_stat) begin
                drop_cnt <= 8'h00;
            end else if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule
